// File: rtl/mul_pkg.sv
// Shared types and helpers for the iterative RV32M multiply sequencer.
package mul_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3
  } mul_func3_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mul_state_e;

  // Operand signedness: UU unsigned x unsigned, SU signed op1 x unsigned op2, SS signed x signed.
  typedef enum logic [1:0] {
    UU,
    SU,
    SS
  } mul_sign_e;

  localparam logic [4:0] OPC_OP        = 5'b01100;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Signedness mode implied by func3; illegal encodings fall into UU and are handled separately.
  function automatic mul_sign_e func3_to_sign(input logic [2:0] f);
    mul_sign_e m;
    case (f)
      MULH:    m = SS;
      MULHSU:  m = SU;
      default: m = UU;
    endcase
    return m;
  endfunction

  // Unsigned magnitude; 0x80000000 maps to itself, read as an unsigned 32-bit value.
  function automatic logic [31:0] mag(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add step: R multiplier bits times the multiplicand, shifted into place and added to the accumulator.
module mul_step #(
  parameter int R = 4
) (
  input  logic [63:0]  acc_i,
  input  logic [31:0]  mcand_i,
  input  logic [R-1:0] bits_i,
  input  logic [5:0]   shamt_i,
  output logic [63:0]  acc_o
);

  logic [63:0] pp;

  // Partial product of the current R-bit slice, aligned by the step offset.
  always_comb begin
    pp    = 64'(mcand_i) * 64'(bits_i);
    acc_o = acc_i + (pp << shamt_i);
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Iterative RV32M multiply sequencer (MUL/MULH/MULHSU/MULHU), R product bits per CALC cycle.
// Optional feature: `define MUL_RESULT_CACHE_EN adds a last-result cache giving 1-cycle hits.
// Handshake: a request is accepted on a rising edge where req_valid && req_ready; req_ready is
// high only in IDLE without flush; resp_valid is a one-cycle strobe and resp_data holds afterwards.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int R    = 4,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_func3,
  input  logic [XLEN-1:0] req_op1,
  input  logic [XLEN-1:0] req_op2,
  input  logic            flush,
  output logic            busy,
  output logic            resp_valid,
  output logic [31:0]     resp_data,
  output logic [1:0]      dbg_state
);

  localparam int STEPS = 32 / R;
  localparam int CNT_W = $clog2(STEPS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  mul_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]     mcand_q, mcand_d;
  logic [31:0]     mplier_q, mplier_d;
  logic [63:0]     acc_q, acc_d;
  logic            neg_q, neg_d;
  logic            hi_sel_q, hi_sel_d;
  logic [31:0]     resp_data_q, resp_data_d;

  logic            accept;
  logic            illegal;
  mul_sign_e       req_mode;
  logic            s1, s2;
  logic [5:0]      shamt;
  logic [63:0]     acc_next;
  logic [63:0]     prod;
  logic [31:0]     result;

`ifdef MUL_RESULT_CACHE_EN
  logic            c_valid_q, c_valid_d;
  logic [XLEN-1:0] c_op1_q, c_op1_d;
  logic [XLEN-1:0] c_op2_q, c_op2_d;
  mul_sign_e       c_mode_q, c_mode_d;
  logic [63:0]     c_prod_q, c_prod_d;
  logic [XLEN-1:0] op1_q, op1_d;
  logic [XLEN-1:0] op2_q, op2_d;
  mul_sign_e       mode_q, mode_d;
  logic            from_calc_q, from_calc_d;
  logic            hit;

  // The low half is mode-independent, so MUL may reuse a product cached under any mode.
  assign hit = c_valid_q && (req_op1 == c_op1_q) && (req_op2 == c_op2_q) &&
               ((req_mode == c_mode_q) || (req_func3 == 3'(MUL)));
`endif

  assign req_ready  = (state_q == IDLE) && !flush;
  assign accept     = req_valid && req_ready;
  assign illegal    = req_func3[2];
  assign req_mode   = func3_to_sign(req_func3);
  assign s1         = (req_mode != UU);
  assign s2         = (req_mode == SS);
  assign shamt      = 6'(int'(cnt_q) * R);
  assign prod       = neg_q ? (~acc_q + 64'd1) : acc_q;
  assign result     = hi_sel_q ? prod[63:32] : prod[31:0];
  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == DONE) && !flush;
  assign resp_data  = resp_valid ? result : resp_data_q;
  assign dbg_state  = state_q;

  mul_step #(.R(R)) u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .bits_i  (mplier_q[R-1:0]),
    .shamt_i (shamt),
    .acc_o   (acc_next)
  );

  // Next-state logic: operand capture on accept, one step per CALC cycle, result latch in DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    neg_d       = neg_q;
    hi_sel_d    = hi_sel_q;
    resp_data_d = resp_data_q;
`ifdef MUL_RESULT_CACHE_EN
    c_valid_d   = c_valid_q;
    c_op1_d     = c_op1_q;
    c_op2_d     = c_op2_q;
    c_mode_d    = c_mode_q;
    c_prod_d    = c_prod_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    mode_d      = mode_q;
    from_calc_d = from_calc_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          mcand_d  = mag(req_op1, s1);
          mplier_d = mag(req_op2, s2);
          neg_d    = (s1 & req_op1[XLEN-1]) ^ (s2 & req_op2[XLEN-1]);
          hi_sel_d = (req_func3 != 3'(MUL));
          acc_d    = '0;
          cnt_d    = '0;
`ifdef MUL_RESULT_CACHE_EN
          op1_d       = req_op1;
          op2_d       = req_op2;
          mode_d      = req_mode;
          from_calc_d = 1'b0;
`endif
          if (illegal) begin
            // Zeroed operands and unsigned low half make the DONE result zero.
            mcand_d  = '0;
            mplier_d = '0;
            neg_d    = 1'b0;
            hi_sel_d = 1'b0;
            state_d  = DONE;
          end
`ifdef MUL_RESULT_CACHE_EN
          else if (hit) begin
            // Cached product is already sign-corrected.
            acc_d   = c_prod_q;
            neg_d   = 1'b0;
            state_d = DONE;
          end
          else begin
            from_calc_d = 1'b1;
            state_d     = CALC;
          end
`else
          else begin
            state_d = CALC;
          end
`endif
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d    = acc_next;
          mplier_d = mplier_q >> R;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!flush) begin
          resp_data_d = result;
`ifdef MUL_RESULT_CACHE_EN
          if (from_calc_q) begin
            c_valid_d = 1'b1;
            c_op1_d   = op1_q;
            c_op2_d   = op2_q;
            c_mode_d  = mode_q;
            c_prod_d  = prod;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      neg_q       <= 1'b0;
      hi_sel_q    <= 1'b0;
      resp_data_q <= '0;
`ifdef MUL_RESULT_CACHE_EN
      c_valid_q   <= 1'b0;
      c_op1_q     <= '0;
      c_op2_q     <= '0;
      c_mode_q    <= UU;
      c_prod_q    <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      mode_q      <= UU;
      from_calc_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      neg_q       <= neg_d;
      hi_sel_q    <= hi_sel_d;
      resp_data_q <= resp_data_d;
`ifdef MUL_RESULT_CACHE_EN
      c_valid_q   <= c_valid_d;
      c_op1_q     <= c_op1_d;
      c_op2_q     <= c_op2_d;
      c_mode_q    <= c_mode_d;
      c_prod_q    <= c_prod_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      mode_q      <= mode_d;
      from_calc_q <= from_calc_d;
`endif
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl (R=4). Honours `define MUL_RESULT_CACHE_EN when set.
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_func3 = 3'd0;
  logic [31:0] req_op1 = 32'd0;
  logic [31:0] req_op2 = 32'd0;
  logic        flush = 1'b0;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [1:0]  dbg_state;

`ifdef MUL_RESULT_CACHE_EN
  localparam bit CACHE   = 1'b1;
  localparam int HIT_LAT = 1;
`else
  localparam bit CACHE   = 1'b0;
  localparam int HIT_LAT = 9;
`endif
  localparam int CALC_LAT = 9;

  int checks = 0;
  int errors = 0;

  mul_seq_ctrl #(.R(4), .XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_func3  (req_func3),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .flush      (flush),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // reference arithmetic: extend each operand per its signedness, multiply, pick a half
  function automatic logic [31:0] ref_mul(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    if (f[2]) return 32'd0;
    ea = (f == 3'd1 || f == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (f == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (f == 3'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic int mode_of(input logic [2:0] f);
    return (f == 3'd1) ? 2 : (f == 3'd2) ? 1 : 0;
  endfunction

  // behavioural model: one in-flight op with a due cycle, last result, last-result cache
  int          cyc = 0;
  bit          m_pend = 1'b0;
  int          m_due = 0;
  logic [31:0] m_data = '0;
  logic [31:0] m_last = '0;
  bit          m_calc = 1'b0;
  logic [31:0] m_a = '0, m_b = '0;
  int          m_mode = 0;
  bit          c_v = 1'b0;
  logic [31:0] c_a = '0, c_b = '0;
  int          c_m = 0;
  bit          e_busy, e_ready, e_valid, m_hit;
  logic [31:0] e_data;

  // compare every cycle, then advance the model with the inputs that the next edge will see
  always @(negedge clk) begin
    if (rst) begin
      m_pend = 1'b0;
      m_last = '0;
      c_v    = 1'b0;
    end
    e_busy  = m_pend;
    e_ready = !m_pend && !flush;
    e_valid = m_pend && (cyc == m_due) && !flush;
    e_data  = e_valid ? m_data : m_last;
    chk("busy", busy, e_busy);
    chk("req_ready", req_ready, e_ready);
    chk("resp_valid", resp_valid, e_valid);
    chk("resp_data", resp_data, e_data);
    if (!rst) begin
      if (m_pend) begin
        if (flush) begin
          m_pend = 1'b0;
        end else if (cyc == m_due) begin
          m_pend = 1'b0;
          m_last = m_data;
          if (m_calc) begin
            c_v = 1'b1;
            c_a = m_a;
            c_b = m_b;
            c_m = m_mode;
          end
        end
      end else if (req_valid && !flush) begin
        m_hit  = CACHE && c_v && !req_func3[2] && (req_op1 == c_a) && (req_op2 == c_b) &&
                 ((mode_of(req_func3) == c_m) || (req_func3 == 3'd0));
        m_pend = 1'b1;
        m_data = ref_mul(req_func3, req_op1, req_op2);
        m_calc = !req_func3[2] && !m_hit;
        m_due  = cyc + 1 + (m_calc ? CALC_LAT - 1 : 0);
        m_a    = req_op1;
        m_b    = req_op2;
        m_mode = mode_of(req_func3);
      end
    end
    cyc++;
  end

  // driver tasks; all called just after a rising edge
  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_func3 = f;
    req_op1   = a;
    req_op2   = b;
  endtask

  task automatic wait_resp(input logic [31:0] exp_d, input int exp_lat, input string nm);
    int          lat = 0;
    int          nbusy = 0;
    logic [31:0] got = '0;
    bit          seen = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (resp_valid) begin
        seen = 1'b1;
        lat  = n;
        got  = resp_data;
        break;
      end
    end
    @(posedge clk); #1;
    chk({nm, "_seen"}, seen, 1);
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_busy_cycles"}, nbusy, exp_lat);
    chk({nm, "_data"}, got, exp_d);
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_d, input int exp_lat, input string nm);
    drive(f, a, b);
    wait_resp(exp_d, exp_lat, nm);
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return 32'(($urandom_range(0, 3)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_ready", req_ready, 1);
    chk("reset_valid", resp_valid, 0);
    chk("reset_data", resp_data, 0);
    @(posedge clk); #1;

    run_op(3'd0, 32'd7, 32'd6, 32'h0000_002A, CALC_LAT, "t1_mul");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, CALC_LAT, "t2_mulh");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, CALC_LAT, "t2_mulhu");
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, CALC_LAT, "t3_mulhsu");
    run_op(3'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, CALC_LAT, "t3_mulh");
    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, HIT_LAT, "t3_mul");

    // flush three cycles into CALC, then accept straight after busy drops
    drive(3'd0, 32'd9, 32'd9);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    chk("t4_flush_valid", resp_valid, 0);
    chk("t4_flush_busy", busy, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    drive(3'd0, 32'd2, 32'd3);
    @(negedge clk);
    chk("t4_busy_after_flush", busy, 0);
    chk("t4_ready_after_flush", req_ready, 1);
    chk("t4_data_kept", resp_data, 32'hFFFF_FFF1);
    wait_resp(32'h0000_0006, CALC_LAT, "t4_mul");

    // flush in IDLE beats req_valid
    drive(3'd0, 32'd1, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    chk("idle_flush_ready", req_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("idle_flush_no_accept", busy, 0);
    @(posedge clk); #1;

    // reset mid-CALC
    drive(3'd0, 32'd5, 32'd5);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_valid", resp_valid, 0);
    chk("t5_rst_data", resp_data, 0);
    chk("t5_rst_ready", req_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(3'b100, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1, "t5_illegal");
    run_op(3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1, "t5_illegal7");

    // cache reuse across modes
    run_op(3'd1, 32'hFFFF_FFF9, 32'h0000_0010, 32'hFFFF_FFFF, CALC_LAT, "t6_mulh");
    run_op(3'd0, 32'hFFFF_FFF9, 32'h0000_0010, 32'hFFFF_FF90, HIT_LAT, "t6_mul");

    // flush in DONE: no strobe, old data kept, and the op must not be cached
    drive(3'd0, 32'd3, 32'd3);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    chk("done_flush_valid", resp_valid, 0);
    chk("done_flush_data", resp_data, 32'hFFFF_FF90);
    @(posedge clk); #1;
    flush = 1'b0;
    run_op(3'd0, 32'd3, 32'd3, 32'd9, CALC_LAT, "done_flush_not_cached");

    // randomized traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      req_valid = ($urandom_range(0, 1) == 1);
      req_func3 = ($urandom_range(0, 7) == 0) ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 3));
      req_op1   = pick_op();
      req_op2   = pick_op();
      flush     = ($urandom_range(0, 24) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    flush     = 1'b0;
    rst       = 1'b0;
    repeat (12) begin @(posedge clk); #1; end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
